// File: rtl/cache_2way.sv
// cache_2way: two-way set-associative tag/data array with per-set LRU victim
// selection, registered compare result and global flush.
// Optional hit/miss statistics counters are enabled by defining CACHE_STATS_EN.
module cache_2way #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned IDX_W  = 6,
   parameter int unsigned DATA_W = 128
) (
   input  logic              CLK,
   input  logic              RSTN,
   input  logic              CEN,
   input  logic              WorC,
   input  logic              FLUSH,
   input  logic [ADDR_W-1:0] A_CPU,
   input  logic [DATA_W-1:0] D,
   output logic [DATA_W-1:0] Q,
   output logic              Hit
`ifdef CACHE_STATS_EN
   ,
   output logic [15:0]       HIT_CNT,
   output logic [15:0]       MISS_CNT
`endif
);

   localparam int unsigned TAG_W = ADDR_W - IDX_W;
   localparam int unsigned SETS  = 2 ** IDX_W;

   // Reject geometries that leave no tag or no index bits
   if (!(ADDR_W > IDX_W && IDX_W >= 1)) begin : g_bad_params
      $error("cache_2way: parameters must satisfy ADDR_W > IDX_W >= 1");
   end

   // Valid and LRU are reset; tag and data arrays are plain storage
   logic [SETS-1:0][1:0] valid;
   logic [SETS-1:0]      lru;
   logic [TAG_W-1:0]     tag_mem  [SETS][2];
   logic [DATA_W-1:0]    data_mem [SETS][2];

   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag_in;
   logic              do_wr;
   logic              do_cmp;
   logic              match0;
   logic              match1;
   logic              hit_c;
   logic              hit_way;
   logic              victim;
   logic [DATA_W-1:0] rd_data;

   // Address split and operation decode (flush beats idle beats write/compare)
   always_comb begin
      idx    = A_CPU[IDX_W-1:0];
      tag_in = A_CPU[ADDR_W-1:IDX_W];
      do_wr  = !FLUSH && !CEN && !WorC;
      do_cmp = !FLUSH && !CEN &&  WorC;
   end

   // Tag match per way; way 0 wins if both somehow match
   always_comb begin
      match0  = valid[idx][0] && (tag_mem[idx][0] == tag_in);
      match1  = valid[idx][1] && (tag_mem[idx][1] == tag_in);
      hit_c   = match0 || match1;
      hit_way = match0 ? 1'b0 : 1'b1;
      rd_data = data_mem[idx][hit_way];
   end

   // Fill victim: matching way, else first invalid way, else the LRU way
   always_comb begin
      victim = lru[idx];
      if (match0)              victim = 1'b0;
      else if (match1)         victim = 1'b1;
      else if (!valid[idx][0]) victim = 1'b0;
      else if (!valid[idx][1]) victim = 1'b1;
   end

   // Control state and registered outputs
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         valid <= '0;
         lru   <= '0;
         Hit   <= 1'b0;
         Q     <= '0;
      end else begin
         Hit <= 1'b0;
         if (FLUSH) begin
            valid <= '0;
            lru   <= '0;
         end else if (do_wr) begin
            valid[idx][victim] <= 1'b1;
            lru[idx]           <= ~victim;
         end else if (do_cmp) begin
            if (hit_c) begin
               Hit      <= 1'b1;
               Q        <= rd_data;
               lru[idx] <= ~hit_way;
            end else begin
               Q <= '0;
            end
         end
      end
   end

   // Tag/data storage; no write lands while reset is held
   always_ff @(posedge CLK) begin
      if (RSTN && do_wr) begin
         tag_mem[idx][victim]  <= tag_in;
         data_mem[idx][victim] <= D;
      end
   end

`ifdef CACHE_STATS_EN
   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   // Saturating hit/miss counters, cleared only by reset
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         HIT_CNT  <= '0;
         MISS_CNT <= '0;
      end else if (do_cmp) begin
         if (hit_c) begin
            if (HIT_CNT != CNT_MAX) HIT_CNT <= HIT_CNT + 16'd1;
         end else begin
            if (MISS_CNT != CNT_MAX) MISS_CNT <= MISS_CNT + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_cache_2way.sv
// tb_cache_2way: randomized and directed checks of cache_2way against a
// behavioural set/way model. Define CACHE_STATS_EN to cover the counters.
`timescale 1ns/1ps
module tb_cache_2way;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned IDX_W  = 6;
   localparam int unsigned DATA_W = 128;
   localparam int unsigned TAG_W  = ADDR_W - IDX_W;
   localparam int unsigned SETS   = 2 ** IDX_W;

   logic              CLK;
   logic              RSTN;
   logic              CEN;
   logic              WorC;
   logic              FLUSH;
   logic [ADDR_W-1:0] A_CPU;
   logic [DATA_W-1:0] D;
   logic [DATA_W-1:0] Q;
   logic              Hit;
`ifdef CACHE_STATS_EN
   logic [15:0]       HIT_CNT;
   logic [15:0]       MISS_CNT;
`endif

   cache_2way #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
      .CLK(CLK), .RSTN(RSTN), .CEN(CEN), .WorC(WorC), .FLUSH(FLUSH),
      .A_CPU(A_CPU), .D(D), .Q(Q), .Hit(Hit)
`ifdef CACHE_STATS_EN
      , .HIT_CNT(HIT_CNT), .MISS_CNT(MISS_CNT)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural reference: resident lines per set and which way to evict
   logic              m_valid [SETS][2];
   logic [TAG_W-1:0]  m_tag   [SETS][2];
   logic [DATA_W-1:0] m_data  [SETS][2];
   logic              m_lru   [SETS];
   logic              m_hit;
   logic [DATA_W-1:0] m_q;
   int                m_hc;
   int                m_mc;

   function automatic void model_reset();
      for (int s = 0; s < int'(SETS); s++) begin
         m_valid[s][0] = 1'b0;
         m_valid[s][1] = 1'b0;
         m_lru[s]      = 1'b0;
      end
      m_hit = 1'b0;
      m_q   = '0;
      m_hc  = 0;
      m_mc  = 0;
   endfunction

   function automatic void model_op(input logic fl, input logic cen, input logic worc,
                                    input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      int s;
      logic [TAG_W-1:0] t;
      int w;
      s = int'(a[IDX_W-1:0]);
      t = a[ADDR_W-1:IDX_W];
      m_hit = 1'b0;
      if (fl) begin
         for (int i = 0; i < int'(SETS); i++) begin
            m_valid[i][0] = 1'b0;
            m_valid[i][1] = 1'b0;
            m_lru[i]      = 1'b0;
         end
      end else if (!cen) begin
         w = -1;
         for (int k = 0; k < 2; k++)
            if (w < 0 && m_valid[s][k] && m_tag[s][k] == t) w = k;
         if (!worc) begin
            if (w < 0) begin
               if (!m_valid[s][0])      w = 0;
               else if (!m_valid[s][1]) w = 1;
               else                     w = m_lru[s] ? 1 : 0;
            end
            m_valid[s][w] = 1'b1;
            m_tag[s][w]   = t;
            m_data[s][w]  = d;
            m_lru[s]      = (w == 0);
         end else if (w >= 0) begin
            m_hit    = 1'b1;
            m_q      = m_data[s][w];
            m_lru[s] = (w == 0);
            if (m_hc < 65535) m_hc++;
         end else begin
            m_q = '0;
            if (m_mc < 65535) m_mc++;
         end
      end
   endfunction

   // One operation: drive at the falling edge, check after the next falling edge
   task automatic step(input string nm, input logic fl, input logic cen, input logic worc,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      FLUSH = fl; CEN = cen; WorC = worc; A_CPU = a; D = d;
      model_op(fl, cen, worc, a, d);
      @(posedge CLK);
      @(negedge CLK);
      n_tests++;
      if (Hit !== m_hit) begin
         n_fail++;
         $display("FAIL %s hit a=%h got=%b exp=%b", nm, a, Hit, m_hit);
      end
      n_tests++;
      if (Q !== m_q) begin
         n_fail++;
         $display("FAIL %s q a=%h got=%h exp=%h", nm, a, Q, m_q);
      end
`ifdef CACHE_STATS_EN
      n_tests++;
      if (HIT_CNT !== 16'(m_hc) || MISS_CNT !== 16'(m_mc)) begin
         n_fail++;
         $display("FAIL %s cnt got=%0d/%0d exp=%0d/%0d", nm, HIT_CNT, MISS_CNT, m_hc, m_mc);
      end
`endif
   endtask

   task automatic wr(input string nm, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      step(nm, 1'b0, 1'b0, 1'b0, a, d);
   endtask

   task automatic cmp(input string nm, input logic [ADDR_W-1:0] a);
      step(nm, 1'b0, 1'b0, 1'b1, a, '0);
   endtask

   task automatic idle(input string nm);
      step(nm, 1'b0, 1'b1, 1'b0, A_CPU, D);
   endtask

   task automatic check_zero_outputs(input string nm);
      n_tests++;
      if (Hit !== 1'b0 || Q !== '0) begin
         n_fail++;
         $display("FAIL %s outputs got hit=%b q=%h exp hit=0 q=0", nm, Hit, Q);
      end
`ifdef CACHE_STATS_EN
      n_tests++;
      if (HIT_CNT !== 16'd0 || MISS_CNT !== 16'd0) begin
         n_fail++;
         $display("FAIL %s counters got=%0d/%0d exp=0/0", nm, HIT_CNT, MISS_CNT);
      end
`endif
   endtask

   task automatic test_reset();
      RSTN = 1'b0; CEN = 1'b1; WorC = 1'b0; FLUSH = 1'b0; A_CPU = '0; D = '0;
      #1;
      check_zero_outputs("reset");
      model_reset();
      repeat (2) @(negedge CLK);
      RSTN = 1'b1;
      cmp("reset_cmp_aaaa", 16'hAAAA);
   endtask

   task automatic test_basic();
      wr("basic_wr", 16'hAAAA, {32{4'hA}});
      cmp("basic_hit", 16'hAAAA);
      n_tests++;
      if (Hit !== 1'b1 || Q !== {32{4'hA}}) begin
         n_fail++;
         $display("FAIL basic_const got hit=%b q=%h exp hit=1 q=%h", Hit, Q, {32{4'hA}});
      end
      cmp("basic_miss", 16'h5555);
   endtask

   task automatic test_conflict();
      wr("cf_wr1", 16'hAAAA, 128'd1);
      wr("cf_wr2", 16'h12AA, 128'd2);
      cmp("cf_hit_aaaa", 16'hAAAA);
      wr("cf_wr3", 16'h22AA, 128'd3);
      cmp("cf_evicted", 16'h12AA);
      n_tests++;
      if (Hit !== 1'b0) begin
         n_fail++;
         $display("FAIL cf_evict_const got hit=%b exp hit=0", Hit);
      end
      cmp("cf_aaaa", 16'hAAAA);
      n_tests++;
      if (Q !== 128'd1) begin
         n_fail++;
         $display("FAIL cf_q1_const got q=%h exp 1", Q);
      end
      cmp("cf_22aa", 16'h22AA);
      n_tests++;
      if (Q !== 128'd3) begin
         n_fail++;
         $display("FAIL cf_q3_const got q=%h exp 3", Q);
      end
   endtask

   task automatic test_rewrite();
      wr("rw_wr", 16'hAAAA, 128'd7);
      cmp("rw_aaaa", 16'hAAAA);
      n_tests++;
      if (Q !== 128'd7) begin
         n_fail++;
         $display("FAIL rw_q7_const got q=%h exp 7", Q);
      end
      cmp("rw_other", 16'h22AA);
      cmp("rw_aaaa2", 16'hAAAA);
   endtask

   task automatic test_flush();
      cmp("fl_pre_hit", 16'hAAAA);
      step("fl_with_write", 1'b1, 1'b0, 1'b0, 16'h0101, {4{32'hDEADBEEF}});
      idle("fl_idle1");
      idle("fl_idle2");
      n_tests++;
      if (Q !== 128'd7) begin
         n_fail++;
         $display("FAIL fl_q_hold got q=%h exp 7", Q);
      end
      cmp("fl_miss_aaaa", 16'hAAAA);
      cmp("fl_miss_22aa", 16'h22AA);
      cmp("fl_miss_0101", 16'h0101);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 40; i++) begin
         logic [ADDR_W-1:0] a;
         logic [DATA_W-1:0] d;
         a = ADDR_W'($urandom);
         d = {$urandom, $urandom, $urandom, $urandom};
         wr("b2b_wr", a, d);
         cmp("b2b_cmp", a);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         int r;
         logic [ADDR_W-1:0] a;
         logic [5:0] s;
         logic [9:0] t;
         r = int'($urandom_range(0, 99));
         case ($urandom_range(0, 2))
            0:       s = 6'h2A;
            1:       s = 6'h05;
            default: s = 6'($urandom);
         endcase
         t = 10'($urandom_range(0, 3));
         a = {t, s};
         if (r < 2)       step("rnd_flush", 1'b1, 1'($urandom), 1'($urandom), a, '0);
         else if (r < 12) step("rnd_idle", 1'b0, 1'b1, 1'($urandom), a, '0);
         else if (r < 50) wr("rnd_wr", a, {$urandom, $urandom, $urandom, $urandom});
         else             cmp("rnd_cmp", a);
      end
   endtask

   task automatic test_async_reset();
      wr("ar_wr", 16'h3C3C, {4{32'h1234_5678}});
      cmp("ar_hit", 16'h3C3C);
      FLUSH = 1'b0; CEN = 1'b0; WorC = 1'b1; A_CPU = 16'h3C3C;
      @(posedge CLK);
      #2;
      RSTN = 1'b0;
      #1;
      check_zero_outputs("async_reset");
      model_reset();
      @(negedge CLK);
      RSTN = 1'b1;
      cmp("ar_after_miss", 16'h3C3C);
   endtask

`ifdef CACHE_STATS_EN
   task automatic test_stats();
      RSTN = 1'b0;
      #1;
      model_reset();
      @(negedge CLK);
      RSTN = 1'b1;
      wr("st_wr", 16'h0F0F, 128'd9);
      for (int i = 0; i < 70000; i++) cmp("st_hit", 16'h0F0F);
      n_tests++;
      if (HIT_CNT !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL st_sat got=%h exp=ffff", HIT_CNT);
      end
      cmp("st_miss", 16'h0F4F);
      step("st_flush", 1'b1, 1'b0, 1'b1, 16'h0F0F, '0);
      test_async_reset();
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_conflict();
      test_rewrite();
      test_flush();
      test_back_to_back();
      test_random();
      test_async_reset();
`ifdef CACHE_STATS_EN
      test_stats();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cache_2way.md
# cache_2way

Parametrised two-way set-associative cache array for the CPU-side memory path. It replaces the single-entry write/compare tag RAM. It stores tag, data and valid bits per way and selects victims with a per-set LRU bit. It returns a registered hit flag and read data one cycle after each compare, and supports a global flush.

## Interface
- ADDR_W, 16: CPU address width.
- IDX_W, 6: set index width; the array has 2^IDX_W sets × 2 ways.
- DATA_W, 128: line width.
- Derived: TAG_W = ADDR_W − IDX_W. The implementation must check ADDR_W > IDX_W ≥ 1 at elaboration.

- CLK  in  1  clock; all state updates on the rising edge.
- RSTN  in  1  asynchronous active-low reset.
- CEN  in  1  chip enable, active low; 1 = idle.
- WorC  in  1  operation select when CEN=0: 0 = write (fill), 1 = compare (lookup).
- FLUSH  in  1  synchronous invalidate of all lines; takes priority over CEN/WorC.
- A_CPU  in  ADDR_W  address. Index = A_CPU[IDX_W-1:0]; tag = A_CPU[ADDR_W-1:IDX_W].
- D  in  DATA_W  fill data.
- Q  out  DATA_W  read data, registered.
- Hit  out  1  compare hit, registered.
- HIT_CNT  out  16  (CACHE_STATS_EN only) compare-hit counter.
- MISS_CNT  out  16  (CACHE_STATS_EN only) compare-miss counter.

## Operation
- Per set: valid[1:0], tag[2][TAG_W], data[2][DATA_W], and lru (the way to evict next).
- Priority at each edge is FLUSH, then CEN=1 (idle), then write, then compare.
- FLUSH=1:
  - All valid bits and all lru bits cleared.
  - Tags and data untouched.
  - Hit <= 0; Q holds.
- Idle (CEN=1): no state change; Hit <= 0; Q holds.
- Write (CEN=0, WorC=0), victim selection in order:
  1. the valid way whose tag matches (overwrite in place);
  2. else way 0 if invalid;
  3. else way 1 if invalid;
  4. else way lru.
- Write actions:
  - Victim gets tag, D, valid=1.
  - lru <= ~victim.
  - Hit <= 0; Q holds.
- Compare (CEN=0, WorC=1):
  - Hit way = valid way with matching tag.
  - On hit: Hit <= 1, Q <= that way's data, lru <= ~hitway.
  - On miss: Hit <= 0, Q <= 0, lru unchanged.
- Both ways valid with an equal tag cannot arise via write; if it does, way 0 wins.
- Compare and write never occur in the same cycle (WorC selects one).
- A write followed by a compare to the same address on the next edge hits (the array is updated at the write edge).

## Timing
- Reset (RSTN=0, asynchronous):
  - Hit=0, Q=0, all valid=0, all lru=0; HIT_CNT=MISS_CNT=0.
  - Tag and data arrays are not reset.
- Reset release is synchronous to the first CLK edge with RSTN=1; reset asserted mid-operation aborts the write (no partial update is visible after reset).
- Latency: Hit/Q valid after the edge that samples the compare; one operation per cycle, fully pipelined, no stall.
- Q and Hit change only at CLK edges or reset.

## Configuration
- CACHE_STATS_EN defined:
  - HIT_CNT/MISS_CNT ports and logic present.
  - Each compare increments exactly one counter at the sampling edge; write/idle/flush do not.
  - Counters saturate at 16'hFFFF; FLUSH does not clear them; only RSTN does.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan
- Reset then compare A_CPU=16'hAAAA -> Hit=0, Q=0; with stats, MISS_CNT=1.
- Write A_CPU=16'hAAAA, D={32{4'hA}}; compare 16'hAAAA next cycle -> Hit=1, Q={32{4'hA}} one cycle later; compare 16'h5555 -> Hit=0, Q=0.
- Conflict on set 6'h2A:
  - Write 16'hAAAA (D=1), write 16'h12AA (D=2), then compare 16'hAAAA -> hit; way 1 becomes LRU.
  - Write 16'h22AA (D=3), which evicts 16'h12AA.
  - Compares: 16'h12AA -> Hit=0; 16'hAAAA -> Q=1; 16'h22AA -> Q=3.
- Rewrite 16'hAAAA with D=7 while resident -> same way overwritten; compares of 16'hAAAA -> Q=7, and the other resident line still hits.
- FLUSH=1 asserted together with CEN=0, WorC=0 -> no write occurs; all subsequent compares miss; CEN=1 cycles keep Hit=0 and Q unchanged.
- Stats: drive 70000 compare hits to one address -> HIT_CNT saturates at 16'hFFFF; assert RSTN=0 mid-burst -> counters, Hit and Q are 0 immediately, without waiting for a clock edge.
